mc_sequencer: RTL and testbench
===============================

MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 Parameter MEM_TIMEOUT, 15, the maximum number of wait cycles for an acknowledge before the block halts on a timeout.
REQ-002 Parameter CNT_W, 16, the width of the retired-instruction counter.
REQ-003 clk  in  1  the single clock; all state changes on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 run  in  1  level; 1 allows new instruction fetches.
REQ-006 imem_req  out  1  instruction fetch request.
REQ-007 imem_ack  in  1  fetch data valid this cycle.
REQ-008 ir_load  out  1  one-cycle strobe that loads the instruction register.
REQ-009 ctrl_in  in  21  decoded control word: [20:19] aluop, [18] mem op, [17] load, [16] mem write, [15] valid, [14:10] rs, [9:5] rt, [4:0] dest/rt.
REQ-010 alu_en  out  1  execute strobe.
REQ-011 aluop  out  2  latched ctrl[20:19].
REQ-012 dmem_req  out  1  data memory request.
REQ-013 dmem_we  out  1  latched ctrl[16], qualified by dmem_req.
REQ-014 dmem_ack  in  1  data access complete.
REQ-015 rf_we  out  1  register-file write strobe.
REQ-016 rf_waddr  out  5  latched ctrl[4:0].
REQ-017 pc_inc  out  1  one-cycle retire strobe.
REQ-018 retired  out  CNT_W  retired-instruction count.
REQ-019 busy  out  1  high in every state except IDLE and HALT.
REQ-020 err_illegal  out  1  sticky illegal-instruction flag.
REQ-021 err_timeout  out  1  sticky memory-timeout flag.

Function
REQ-022 The FSM SHALL have the states IDLE, FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-023 IDLE: go to FETCH when run=1; otherwise stay in IDLE.
REQ-024 FETCH: assert imem_req; on imem_ack, pulse ir_load and go to DECODE.
REQ-025 DECODE (1 cycle): latch ctrl_in into ctrl_q; if ctrl_in[15]=0, set err_illegal and go to HALT; otherwise go to EXEC.
REQ-026 EXEC (1 cycle): assert alu_en; go to MEM if ctrl_q[18]=1, otherwise to WB.
REQ-027 MEM: assert dmem_req; on dmem_ack, go to WB if ctrl_q[17]=1; otherwise retire the store and go to FETCH or IDLE.
REQ-028 WB (1 cycle): assert rf_we (suppressed when rf_waddr=0); retire; go to FETCH if run=1, otherwise to IDLE.
REQ-029 Retire SHALL mean pc_inc=1 for exactly one cycle and retired incremented by 1, wrapping from all-ones to 0.
REQ-030 Latency with zero-wait acknowledges, from entering FETCH to pc_inc:
  - ALU instruction: 4 cycles.
  - store: 4 cycles.
  - load: 5 cycles.
REQ-031 The wait counter SHALL clear on entry to FETCH or MEM and increment on each cycle without an acknowledge; reaching MEM_TIMEOUT SHALL set err_timeout and go to HALT with no retire.
REQ-032 An acknowledge arriving in the same cycle the counter reaches MEM_TIMEOUT SHALL take priority (normal completion).
REQ-033 An acknowledge arriving outside FETCH or MEM SHALL be ignored.
REQ-034 Deasserting run mid-instruction SHALL let the current instruction complete and retire, then enter IDLE.
REQ-035 HALT SHALL be left only by reset; all strobes SHALL be 0 in HALT.
REQ-036 dmem_we SHALL be 0 whenever dmem_req=0.

Reset
REQ-037 rst SHALL immediately force:
  - state IDLE;
  - ctrl_q, retired and the wait counter to 0;
  - every output to 0.
REQ-038 Reset asserted mid-operation SHALL abandon the instruction with no retire and no rf_we.
REQ-039 The first fetch after reset SHALL occur in the cycle after rst deasserts with run=1.

Structure
REQ-040 A shared package mc_pkg SHALL hold:
  - the state enum;
  - the ctrl field bit positions;
  - the MEM_TIMEOUT default.
REQ-041 The wait counter SHALL be a separate sub-module, mc_watchdog (clear, count, expired).

Verification
REQ-042 run=1, zero-wait acks, ADD (valid, aluop=10, rd=3):
  - ir_load at cycle 1, alu_en at cycle 3;
  - rf_we with rf_waddr=3 and pc_inc at cycle 4;
  - retired=1.
REQ-043 LW (mem op, load, rt=5), dmem_ack delayed 3 cycles:
  - dmem_req held 4 cycles, dmem_we=0;
  - rf_waddr=5 in WB; pc_inc 8 cycles after FETCH entry.
REQ-044 SW with immediate ack:
  - dmem_we=1 for 1 cycle;
  - no rf_we; pc_inc in the ack cycle.
REQ-045 ctrl_in all-zero in DECODE:
  - err_illegal=1, state HALT;
  - imem_req stays 0 thereafter; retired unchanged.
REQ-046 dmem_ack never arrives:
  - err_timeout=1 exactly 15 cycles after MEM entry;
  - no pc_inc.
  Separately, ack in the 15th cycle: normal completion.
REQ-047 retired preset near wrap via 65535 retires:
  - the next retire gives 0.
  Then rst asserted in MEM:
  - outputs 0 asynchronously;
  - IDLE after deassert with run=0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the micro-coded sequencer: FSM states, control-word
// field positions and the default acknowledge timeout.
package mc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  // Decoded control word layout
  localparam int CTRL_W    = 21;
  localparam int ALUOP_HI  = 20;
  localparam int ALUOP_LO  = 19;
  localparam int MEMOP_BIT = 18;
  localparam int LOAD_BIT  = 17;
  localparam int WE_BIT    = 16;
  localparam int VALID_BIT = 15;
  localparam int RS_HI     = 14;
  localparam int RS_LO     = 10;
  localparam int RT_HI     = 9;
  localparam int RT_LO     = 5;
  localparam int DEST_HI   = 4;
  localparam int DEST_LO   = 0;

  // Wait cycles tolerated for an acknowledge before the sequencer halts
  localparam int MEM_TIMEOUT_DEF = 15;

endpackage

// File: rtl/mc_if.sv
// Sequencer-to-environment bus: fetch/data handshakes, control word in,
// execute/write-back strobes and status out.
interface mc_if
  import mc_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic              run;
  logic              imem_req;
  logic              imem_ack;
  logic              ir_load;
  logic [CTRL_W-1:0] ctrl_in;
  logic              alu_en;
  logic [1:0]        aluop;
  logic              dmem_req;
  logic              dmem_we;
  logic              dmem_ack;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic              pc_inc;
  logic [CNT_W-1:0]  retired;
  logic              busy;
  logic              err_illegal;
  logic              err_timeout;

  // The sequencer side
  modport master (
    input  run, imem_ack, ctrl_in, dmem_ack,
    output imem_req, ir_load, alu_en, aluop, dmem_req, dmem_we,
           rf_we, rf_waddr, pc_inc, retired, busy, err_illegal, err_timeout
  );

  // The memory / datapath side
  modport slave (
    output run, imem_ack, ctrl_in, dmem_ack,
    input  imem_req, ir_load, alu_en, aluop, dmem_req, dmem_we,
           rf_we, rf_waddr, pc_inc, retired, busy, err_illegal, err_timeout
  );
endinterface

// File: rtl/mc_watchdog.sv
// Acknowledge wait counter. Cleared when a waiting state is entered, counts
// each cycle the acknowledge is missing, and flags the miss that would bring
// it to LIMIT so the caller can abort in that same cycle.
module mc_watchdog #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise saturating increment while counting
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count && (cnt_q != W'(LIMIT))) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  assign expired = count && (cnt_q == W'(LIMIT - 1));

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, optional data
// memory access and register write-back, with retire counting and sticky
// illegal-instruction / memory-timeout halts.
module mc_sequencer
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = 16
) (
  input  logic clk,
  input  logic rst,
  mc_if.master bus
);

  state_t            state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              err_illegal_q, err_illegal_d;
  logic              err_timeout_q, err_timeout_d;

  logic imem_req, ir_load, alu_en, dmem_req, dmem_we, rf_we, pc_inc;
  logic wd_clear, wd_count, wd_expired;

  // Only the waiting states count missing acknowledges; acks elsewhere are ignored
  assign wd_count = ((state_q == S_FETCH) && !bus.imem_ack) ||
                    ((state_q == S_MEM)   && !bus.dmem_ack);
  assign wd_clear = (state_d != state_q) &&
                    ((state_d == S_FETCH) || (state_d == S_MEM));

  mc_watchdog #(.LIMIT(MEM_TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .count   (wd_count),
    .expired (wd_expired)
  );

  // Next-state, strobes and retire bookkeeping
  always_comb begin
    state_d       = state_q;
    ctrl_d        = ctrl_q;
    retired_d     = retired_q;
    err_illegal_d = err_illegal_q;
    err_timeout_d = err_timeout_q;
    imem_req      = 1'b0;
    ir_load       = 1'b0;
    alu_en        = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    rf_we         = 1'b0;
    pc_inc        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.run) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ack) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end else if (wd_expired) begin
          err_timeout_d = 1'b1;
          state_d       = S_HALT;
        end
      end
      S_DECODE: begin
        ctrl_d = bus.ctrl_in;
        if (!bus.ctrl_in[VALID_BIT]) begin
          err_illegal_d = 1'b1;
          state_d       = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_en  = 1'b1;
        state_d = ctrl_q[MEMOP_BIT] ? S_MEM : S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = ctrl_q[WE_BIT];
        if (bus.dmem_ack) begin
          if (ctrl_q[LOAD_BIT]) begin
            state_d = S_WB;
          end else begin
            // Stores have nothing to write back and retire here
            pc_inc  = 1'b1;
            state_d = bus.run ? S_FETCH : S_IDLE;
          end
        end else if (wd_expired) begin
          err_timeout_d = 1'b1;
          state_d       = S_HALT;
        end
      end
      S_WB: begin
        rf_we   = (ctrl_q[DEST_HI:DEST_LO] != '0);
        pc_inc  = 1'b1;
        state_d = bus.run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (pc_inc) retired_d = retired_q + CNT_W'(1);
  end

  // State, latched control word, counter and sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ctrl_q        <= '0;
      retired_q     <= '0;
      err_illegal_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ctrl_q        <= ctrl_d;
      retired_q     <= retired_d;
      err_illegal_q <= err_illegal_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  // rs/rt feed the datapath directly; the sequencer only carries them along
  logic unused_rs_rt;
  assign unused_rs_rt = ^{ctrl_q[RS_HI:RS_LO], ctrl_q[RT_HI:RT_LO]};

  assign bus.imem_req    = imem_req;
  assign bus.ir_load     = ir_load;
  assign bus.alu_en      = alu_en;
  assign bus.aluop       = ctrl_q[ALUOP_HI:ALUOP_LO];
  assign bus.dmem_req    = dmem_req;
  assign bus.dmem_we     = dmem_we;
  assign bus.rf_we       = rf_we;
  assign bus.rf_waddr    = ctrl_q[DEST_HI:DEST_LO];
  assign bus.pc_inc      = pc_inc;
  assign bus.retired     = retired_q;
  assign bus.busy        = (state_q != S_IDLE) && (state_q != S_HALT);
  assign bus.err_illegal = err_illegal_q;
  assign bus.err_timeout = err_timeout_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: a directed vector table, randomized
// instructions scored by a latency/side-effect model, and hand sequences for
// wrap, reset-in-MEM, illegal instruction and timeout.
module tb_mc_sequencer;

  // Narrow counter keeps the wrap-around sequence short
  localparam int TB_CNT_W = 8;
  localparam int RET_MASK = (1 << TB_CNT_W) - 1;

  logic clk;
  logic rst;
  int   n_err    = 0;
  int   n_checks = 0;
  int   exp_ret  = 0;

  mc_if #(.CNT_W(TB_CNT_W)) bif ();

  mc_sequencer #(.MEM_TIMEOUT(15), .CNT_W(TB_CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    string       name;
    logic [20:0] ctrl;
    int          fd;
    int          md;
    bit          drop;
    int          lat;
    int          rfwe;
    int          dwe;
    int          dreq;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [20:0] mk(input logic [1:0] op, input logic mo, input logic ld,
                                     input logic we, input logic vd, input logic [9:0] rsrt,
                                     input logic [4:0] d);
    return {op, mo, ld, we, vd, rsrt, d};
  endfunction

  // Reference model: cycle counts and side effects from the instruction class
  task automatic model(input logic [20:0] c, input int fd, input int md,
                       output int lat, output int rfwe, output int dwe, output int dreq);
    bit memop, load, store;
    memop = c[18];
    load  = c[17];
    store = memop && !load;
    lat   = (fd + 1) + 2 + (memop ? md + 1 : 0) + (store ? 0 : 1);
    rfwe  = (!store && c[4:0] != 5'd0) ? 1 : 0;
    dwe   = (memop && c[16]) ? md + 1 : 0;
    dreq  = memop ? md + 1 : 0;
  endtask

  // Drive one cycle's inputs at the falling edge
  task automatic step(input logic ia, input logic da, input logic [20:0] c);
    @(negedge clk);
    bif.imem_ack = ia;
    bif.dmem_ack = da;
    bif.ctrl_in  = c;
  endtask

  task automatic do_reset(input bit run_after);
    @(negedge clk);
    rst = 1'b1;
    bif.run = 1'b0;
    bif.imem_ack = 1'b0;
    bif.dmem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bif.run = run_after;
    exp_ret = 0;
  endtask

  // Run one instruction whose FETCH cycle is the next negedge
  task automatic run_instr(input string name, input logic [20:0] ctrl, input int fd,
                           input int md, input bit noise, input bit drop, input int e_lat,
                           input int e_rfwe, input int e_dwe, input int e_dreq);
    int cyc = 0, fw = 0, mw = 0, ir_c = 0, pc_c = 0;
    int rf_n = 0, dwe_n = 0, dreq_n = 0, alu_n = 0;
    logic [4:0] wa = '0;
    logic [1:0] op_seen = '0;
    bit done = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (drop && cyc == 2) bif.run = 1'b0;
      bif.ctrl_in = ctrl;
      if (bif.imem_req) begin
        bif.imem_ack = (fw == fd);
        fw++;
      end else begin
        bif.imem_ack = noise ? 1'($urandom_range(1, 0)) : 1'b0;
      end
      if (bif.dmem_req) begin
        bif.dmem_ack = (mw == md);
        mw++;
      end else begin
        bif.dmem_ack = noise ? 1'($urandom_range(1, 0)) : 1'b0;
      end
      #1;
      if (bif.ir_load) ir_c = cyc;
      if (bif.alu_en) begin alu_n++; op_seen = bif.aluop; end
      if (bif.dmem_req) dreq_n++;
      if (bif.dmem_we) dwe_n++;
      if (bif.rf_we) begin rf_n++; wa = bif.rf_waddr; end
      if (bif.pc_inc) begin pc_c = cyc; done = 1; end
    end
    check({name, " retire_seen"}, done, 1);
    check({name, " latency"}, pc_c, e_lat);
    check({name, " ir_load_cycle"}, ir_c, fd + 1);
    check({name, " alu_en_count"}, alu_n, 1);
    check({name, " aluop"}, op_seen, ctrl[20:19]);
    check({name, " dmem_req_cycles"}, dreq_n, e_dreq);
    check({name, " dmem_we_cycles"}, dwe_n, e_dwe);
    check({name, " rf_we_count"}, rf_n, e_rfwe);
    if (e_rfwe != 0) check({name, " rf_waddr"}, wa, ctrl[4:0]);
    @(posedge clk);
    #1;
    exp_ret = (exp_ret + 1) & RET_MASK;
    check({name, " retired"}, bif.retired, exp_ret);
    if (drop) begin
      @(negedge clk);
      bif.imem_ack = 1'b0;
      bif.dmem_ack = 1'b0;
      #1;
      check({name, " idle_busy"}, bif.busy, 0);
      check({name, " idle_no_fetch"}, bif.imem_req, 0);
      bif.run = 1'b1;
    end
  endtask

  initial begin
    logic [20:0] lw5, c;
    int lat, rfwe, dwe, dreq, cnt, first, pcn;

    tbl[0] = '{"add",         mk(2'b10, 0, 0, 0, 1, 10'd0, 5'd3),  0,  0, 0,  4, 1, 0,  0};
    tbl[1] = '{"lw_wait3",    mk(2'b00, 1, 1, 0, 1, 10'd0, 5'd5),  0,  3, 0,  8, 1, 0,  4};
    tbl[2] = '{"sw_fast",     mk(2'b01, 1, 0, 1, 1, 10'd0, 5'd9),  0,  0, 0,  4, 0, 1,  1};
    tbl[3] = '{"alu_r0",      mk(2'b11, 0, 0, 0, 1, 10'd0, 5'd0),  0,  0, 0,  4, 0, 0,  0};
    tbl[4] = '{"lw_ack15",    mk(2'b00, 1, 1, 0, 1, 10'd0, 5'd5),  0, 14, 0, 19, 1, 0, 15};
    tbl[5] = '{"sw_waits",    mk(2'b00, 1, 0, 1, 1, 10'd0, 5'd2),  2,  1, 0,  7, 0, 2,  2};
    tbl[6] = '{"fetch_ack15", mk(2'b10, 0, 0, 0, 1, 10'd0, 5'd7), 14,  0, 0, 18, 1, 0,  0};
    tbl[7] = '{"add_stop",    mk(2'b10, 0, 0, 0, 1, 10'd0, 5'd4),  0,  0, 1,  4, 1, 0,  0};
    tbl[8] = '{"sw_stop",     mk(2'b00, 1, 0, 1, 1, 10'd0, 5'd6),  0,  2, 1,  6, 0, 3,  3};
    tbl[9] = '{"ld_r0",       mk(2'b00, 1, 1, 0, 1, 10'd0, 5'd0),  0,  1, 0,  6, 0, 0,  2};
    lw5 = mk(2'b00, 1, 1, 0, 1, 10'd0, 5'd5);

    // Reset state
    rst = 1'b1;
    bif.run = 1'b0;
    bif.imem_ack = 1'b0;
    bif.dmem_ack = 1'b0;
    bif.ctrl_in = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_strobes", {bif.imem_req, bif.ir_load, bif.alu_en, bif.dmem_req,
                          bif.dmem_we, bif.rf_we, bif.pc_inc}, 0);
    check("rst_status", {bif.busy, bif.err_illegal, bif.err_timeout}, 0);
    check("rst_retired", bif.retired, 0);
    check("rst_fields", {bif.aluop, bif.rf_waddr}, 0);
    @(negedge clk);
    rst = 1'b0;
    bif.run = 1'b1;

    // Directed vectors
    for (int i = 0; i < 10; i++) begin
      run_instr(tbl[i].name, tbl[i].ctrl, tbl[i].fd, tbl[i].md, 1'b0, tbl[i].drop,
                tbl[i].lat, tbl[i].rfwe, tbl[i].dwe, tbl[i].dreq);
    end

    // Randomized instructions with stray acknowledges outside the waiting states
    for (int i = 0; i < 40; i++) begin
      int t;
      t = $urandom_range(2, 0);
      c = mk(2'($urandom), t != 0, t == 1, t == 2, 1'b1, 10'($urandom), 5'($urandom));
      begin
        int fd, md;
        bit drop;
        fd = $urandom_range(5, 0);
        md = $urandom_range(5, 0);
        drop = ($urandom_range(7, 0) == 0);
        model(c, fd, md, lat, rfwe, dwe, dreq);
        run_instr($sformatf("rand%0d", i), c, fd, md, 1'b1, drop, lat, rfwe, dwe, dreq);
      end
    end

    // Retire until the counter is all-ones, then one more wraps it to zero
    cnt = 0;
    while (exp_ret != RET_MASK && cnt < 400) begin
      run_instr("fill", tbl[0].ctrl, 0, 0, 1'b0, 1'b0, 4, 1, 0, 0);
      cnt++;
    end
    check("fill_reached_max", bif.retired, RET_MASK);
    run_instr("wrap", tbl[0].ctrl, 0, 0, 1'b0, 1'b0, 4, 1, 0, 0);
    check("wrap_zero", bif.retired, 0);
    run_instr("post_wrap", tbl[0].ctrl, 0, 0, 1'b0, 1'b0, 4, 1, 0, 0);

    // Reset asserted while waiting in MEM
    step(1'b1, 1'b0, lw5);
    step(1'b0, 1'b0, lw5);
    step(1'b0, 1'b0, lw5);
    step(1'b0, 1'b0, lw5);
    #1;
    check("mem_wait_req", bif.dmem_req, 1);
    step(1'b0, 1'b0, lw5);
    #1;
    rst = 1'b1;
    bif.run = 1'b0;
    #1;
    check("async_rst_strobes", {bif.imem_req, bif.ir_load, bif.alu_en, bif.dmem_req,
                                bif.dmem_we, bif.rf_we, bif.pc_inc, bif.busy}, 0);
    check("async_rst_fields", {bif.rf_waddr, bif.retired}, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_ret = 0;
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (bif.busy || bif.imem_req || bif.rf_we || bif.pc_inc) cnt++;
    end
    check("idle_after_rst", cnt, 0);
    check("no_retire_after_rst", bif.retired, 0);

    // Illegal instruction halts; nothing is fetched afterwards
    @(negedge clk);
    bif.run = 1'b1;
    @(negedge clk);
    #1;
    check("first_fetch", bif.imem_req, 1);
    bif.imem_ack = 1'b1;
    bif.ctrl_in = '0;
    step(1'b0, 1'b0, 21'd0);
    @(negedge clk);
    #1;
    check("illegal_flag", bif.err_illegal, 1);
    check("illegal_not_busy", bif.busy, 0);
    cnt = 0;
    repeat (20) begin
      step(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 21'($urandom));
      #1;
      if (bif.imem_req || bif.ir_load || bif.alu_en || bif.dmem_req || bif.rf_we || bif.pc_inc)
        cnt++;
    end
    check("halt_strobes", cnt, 0);
    check("halt_retired", bif.retired, exp_ret);
    check("halt_illegal_sticky", bif.err_illegal, 1);

    // Data acknowledge never arrives
    do_reset(1'b1);
    step(1'b1, 1'b0, lw5);
    step(1'b0, 1'b0, lw5);
    step(1'b0, 1'b0, lw5);
    cnt = 0;
    first = 0;
    pcn = 0;
    for (int k = 1; k <= 30; k++) begin
      step(1'b0, 1'b0, lw5);
      #1;
      if (bif.dmem_req) cnt++;
      if (bif.pc_inc) pcn++;
      if (bif.err_timeout && first == 0) first = k;
    end
    check("timeout_cycle", first, 16);
    check("timeout_req_cycles", cnt, 15);
    check("timeout_no_retire", pcn, 0);
    check("timeout_retired", bif.retired, 0);
    check("timeout_not_busy", bif.busy, 0);
    check("timeout_no_illegal", bif.err_illegal, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
